// File: rtl/rram_bitserial_mvm_ctrl.sv
// Bit-serial MVM sequencer for the RRAM bit-plane dot-product array.
// Ports: clk_i/rst_i/clear_i; in_* vector handshake; dotp_* datapath; out_* results; busy_o, op_count_o.
module rram_bitserial_mvm_ctrl #(
  parameter int RRAM_DOTP_HEIGHT = 512,
  parameter int RRAM_DOTP_WIDTH  = 512,
  parameter int VEC_BITS         = 8,
  parameter int PART_WIDTH       = 16,
  localparam int ACC_WIDTH       = PART_WIDTH + VEC_BITS
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [RRAM_DOTP_HEIGHT*VEC_BITS-1:0]  in_vec_i,
  output logic [RRAM_DOTP_HEIGHT-1:0]           dotp_bits_o,
  input  logic [RRAM_DOTP_WIDTH*PART_WIDTH-1:0] dotp_result_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [RRAM_DOTP_WIDTH*ACC_WIDTH-1:0]  out_result_o,
  output logic                                  busy_o,
  output logic [31:0]                           op_count_o
);

  localparam int CNT_W = (VEC_BITS > 1) ? $clog2(VEC_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [RRAM_DOTP_HEIGHT*VEC_BITS-1:0]            vec_q, vec_d;
  logic [RRAM_DOTP_WIDTH-1:0][ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]                                cnt_q, cnt_d;
  logic [31:0]                                     op_count_q, op_count_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      op_count_q <= op_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    op_count_d = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          vec_d   = in_vec_i;
          acc_d   = '0;
          cnt_d   = CNT_W'(VEC_BITS - 1);
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // MSB plane first: shift then add this plane's zero-extended partial.
        for (int i = 0; i < RRAM_DOTP_WIDTH; i++) begin
          acc_d[i] = (acc_q[i] << 1)
                   + ACC_WIDTH'(dotp_result_i[i*PART_WIDTH +: PART_WIDTH]);
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          op_count_d = op_count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Soft abort overrides any handshake decided above.
    if (clear_i) begin
      state_d    = IDLE;
      vec_d      = vec_q;
      acc_d      = '0;
      cnt_d      = '0;
      op_count_d = op_count_q;
    end
  end

  always_comb begin
    dotp_bits_o = '0;
    if (state_q == COMPUTE) begin
      for (int j = 0; j < RRAM_DOTP_HEIGHT; j++) begin
        dotp_bits_o[j] = vec_q[j*VEC_BITS + int'(cnt_q)];
      end
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign out_result_o = (state_q == DONE) ? acc_q : '0;
  assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_rram_bitserial_mvm_ctrl.sv
// Directed bench for rram_bitserial_mvm_ctrl with a behavioural dot-product array.
// HEIGHT=4, WIDTH=2, VEC_BITS=4, PART_WIDTH=10 (ACC_WIDTH=14).
module tb_rram_bitserial_mvm_ctrl;

  localparam int H  = 4;
  localparam int W  = 2;
  localparam int VB = 4;
  localparam int PW = 10;
  localparam int AW = PW + VB;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            clear_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [H*VB-1:0] in_vec_i;
  logic [H-1:0]    dotp_bits_o;
  logic [W*PW-1:0] dotp_result_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [W*AW-1:0] out_result_o;
  logic            busy_o;
  logic [31:0]     op_count_o;

  int tests = 0;
  int fails = 0;

  logic [PW-1:0] wt [W][H];

  rram_bitserial_mvm_ctrl #(
    .RRAM_DOTP_HEIGHT(H),
    .RRAM_DOTP_WIDTH (W),
    .VEC_BITS        (VB),
    .PART_WIDTH      (PW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_vec_i     (in_vec_i),
    .dotp_bits_o  (dotp_bits_o),
    .dotp_result_i(dotp_result_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .busy_o       (busy_o),
    .op_count_o   (op_count_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin : dp_model
    int s;
    dotp_result_i = '0;
    for (int i = 0; i < W; i++) begin
      s = 0;
      for (int j = 0; j < H; j++) begin
        if (dotp_bits_o[j]) s = s + int'(wt[i][j]);
      end
      dotp_result_i[i*PW +: PW] = PW'(s);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_w(input logic [PW-1:0] a0, a1, a2, a3,
                       input logic [PW-1:0] b0, b1, b2, b3);
    wt[0][0] = a0; wt[0][1] = a1; wt[0][2] = a2; wt[0][3] = a3;
    wt[1][0] = b0; wt[1][1] = b1; wt[1][2] = b2; wt[1][3] = b3;
  endtask

  // Accept a vector with out_ready_i already high, wait for DONE, check.
  task automatic run_op(input string tag, input logic [H*VB-1:0] v,
                        input logic [AW-1:0] e0, input logic [AW-1:0] e1);
    int n;
    out_ready_i = 1'b1;
    in_vec_i    = v;
    in_valid_i  = 1'b1;
    step();
    in_valid_i  = 1'b0;
    in_vec_i    = '1;
    n = 0;
    while (!out_valid_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_res"}, 64'(out_result_o), 64'({e1, e0}));
    step();
    out_ready_i = 1'b0;
    chk({tag, "_idle"}, 64'(in_ready_o), 64'd1);
  endtask

  logic [H*VB-1:0] vecs [4];
  logic [AW-1:0]   ex0  [4];
  logic [AW-1:0]   ex1  [4];
  logic [W*AW-1:0] held;

  initial begin
    rst_i       = 1'b1;
    clear_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    in_vec_i    = '0;
    set_w(1, 1, 1, 1, 1, 0, 0, 2);
    step();
    step();
    rst_i = 1'b0;

    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_oval", 64'(out_valid_o), 64'd0);
    chk("rst_opcnt", 64'(op_count_o), 64'd0);
    chk("rst_bits", 64'(dotp_bits_o), 64'd0);
    chk("rst_res", 64'(out_result_o), 64'd0);

    // Vector [1,2,3,4]: planes 3..0 are 0000, 1000, 0110, 0101.
    in_vec_i   = 16'h4321;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    in_vec_i   = 16'hFFFF;
    chk("c1_busy", 64'(busy_o), 64'd1);
    chk("c1_ready", 64'(in_ready_o), 64'd0);
    chk("c1_plane3", 64'(dotp_bits_o), 64'h0);
    step();
    chk("c1_plane2", 64'(dotp_bits_o), 64'h8);
    step();
    chk("c1_plane1", 64'(dotp_bits_o), 64'h6);
    step();
    chk("c1_plane0", 64'(dotp_bits_o), 64'h5);
    chk("c1_noval", 64'(out_valid_o), 64'd0);
    step();
    chk("c1_oval", 64'(out_valid_o), 64'd1);
    chk("c1_res", 64'(out_result_o), 64'({14'd9, 14'd10}));
    chk("c1_bits0", 64'(dotp_bits_o), 64'd0);

    held       = out_result_o;
    in_valid_i = 1'b1;
    in_vec_i   = 16'h1111;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("hold_res", 64'(out_result_o), 64'(held));
      chk("hold_ready", 64'(in_ready_o), 64'd0);
      chk("hold_oval", 64'(out_valid_o), 64'd1);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("h_opcnt", 64'(op_count_o), 64'd1);
    chk("h_ready", 64'(in_ready_o), 64'd1);
    chk("h_oval", 64'(out_valid_o), 64'd0);
    chk("h_res0", 64'(out_result_o), 64'd0);

    // Full-scale operands: 15 * (4*255) = 15300 per column.
    set_w(255, 255, 255, 255, 255, 255, 255, 255);
    run_op("max", 16'hFFFF, 14'd15300, 14'd15300);
    chk("max_opcnt", 64'(op_count_o), 64'd2);

    // Abort on the second COMPUTE cycle.
    set_w(1, 1, 1, 1, 1, 0, 0, 2);
    in_vec_i   = 16'h4321;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clr_busy", 64'(busy_o), 64'd0);
    chk("clr_ready", 64'(in_ready_o), 64'd1);
    chk("clr_bits", 64'(dotp_bits_o), 64'd0);
    chk("clr_oval", 64'(out_valid_o), 64'd0);
    chk("clr_opcnt", 64'(op_count_o), 64'd2);
    clear_i    = 1'b1;
    in_valid_i = 1'b1;
    step();
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("clr_prio", 64'(busy_o), 64'd0);
    run_op("post_clr", 16'h1705, 14'd13, 14'd7);
    chk("pc_opcnt", 64'(op_count_o), 64'd3);

    // Reset mid-COMPUTE after three completed ops.
    in_vec_i   = 16'h4321;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mr_opcnt", 64'(op_count_o), 64'd0);
    chk("mr_ready", 64'(in_ready_o), 64'd1);
    chk("mr_oval", 64'(out_valid_o), 64'd0);
    chk("mr_busy", 64'(busy_o), 64'd0);

    // Back-to-back streaming.
    vecs[0] = 16'h4321; ex0[0] = 14'd10; ex1[0] = 14'd9;
    vecs[1] = 16'h1705; ex0[1] = 14'd13; ex1[1] = 14'd7;
    vecs[2] = 16'hF00F; ex0[2] = 14'd30; ex1[2] = 14'd45;
    vecs[3] = 16'h2222; ex0[3] = 14'd8;  ex1[3] = 14'd6;
    begin
      int a, k, cyc, last;
      a = 1; k = 0; cyc = 0; last = 0;
      in_vec_i    = vecs[0];
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      while (k < 4 && cyc < 60) begin
        step();
        cyc++;
        if (out_valid_o) begin
          chk("b2b_res", 64'(out_result_o), 64'({ex1[k], ex0[k]}));
          if (k > 0) chk("b2b_gap", 64'(cyc - last), 64'd6);
          last = cyc;
          k++;
        end
        if (in_ready_o) begin
          in_vec_i = vecs[a % 4];
          a++;
        end
      end
      chk("b2b_count", 64'(k), 64'd4);
      in_valid_i  = 1'b0;
      step();
      out_ready_i = 1'b0;
      chk("b2b_opcnt", 64'(op_count_o), 64'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
